// File: rtl/washer_pkg.sv
// washer_pkg: shared actuator indices, dwell FSM state type and default
// weights/limits for the washer actuator arbiter and its dwell FSMs.
package washer_pkg;

  localparam int IDX_VALVE  = 0;
  localparam int IDX_HEATER = 1;
  localparam int IDX_DRAIN  = 2;
  localparam int IDX_MOTOR  = 3;
  localparam int N_ACT      = 4;

  localparam logic [4:0] DEF_BUDGET   = 5'd10;
  localparam logic [3:0] DEF_W_VALVE  = 4'd1;
  localparam logic [3:0] DEF_W_HEATER = 4'd8;
  localparam logic [3:0] DEF_W_DRAIN  = 4'd2;
  localparam logic [3:0] DEF_W_MOTOR  = 4'd5;

  localparam logic [7:0] DEF_MIN_ON  = 8'd4;
  localparam logic [7:0] DEF_MIN_OFF = 8'd4;
  localparam logic [9:0] DEF_HEATER_LEVEL = 10'd120;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_COOL = 2'd2
  } dwell_state_t;

  function automatic logic fits(
    input logic [6:0] used,
    input logic [3:0] weight,
    input logic [4:0] budget
  );
    return (used + {3'b000, weight}) <= {2'b00, budget};
  endfunction

  function automatic logic [6:0] add_w(
    input logic [6:0] used,
    input logic [3:0] weight
  );
    return used + {3'b000, weight};
  endfunction

endpackage

// File: rtl/actuator_dwell.sv
// actuator_dwell: one actuator's OFF/ON/COOLDOWN FSM with the shared
// counter that enforces the minimum on-time and the cooldown length.
module actuator_dwell
  import washer_pkg::*;
#(
  parameter logic [7:0] MIN_ON  = DEF_MIN_ON,
  parameter logic [7:0] MIN_OFF = DEF_MIN_OFF
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic start,
  input  logic hold_ok,
  output logic on,
  output logic ready
);

  dwell_state_t state;
  dwell_state_t state_nxt;
  logic [7:0]   cnt;
  logic [7:0]   cnt_nxt;
  logic         off_done;

  assign off_done = (cnt >= MIN_OFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_OFF;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A finished cooldown is treated as OFF so the grant-low gap is
  // exactly MIN_OFF cycles when the request is still pending.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_OFF: begin
        if (start) begin
          state_nxt = ST_ON;
          cnt_nxt   = 8'd1;
        end
      end
      ST_ON: begin
        if (!hold_ok || (!req && (cnt >= MIN_ON))) begin
          state_nxt = ST_COOL;
          cnt_nxt   = 8'd1;
        end else if (cnt != 8'hFF) begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      ST_COOL: begin
        if (!off_done) begin
          cnt_nxt = cnt + 8'd1;
        end else if (start) begin
          state_nxt = ST_ON;
          cnt_nxt   = 8'd1;
        end else begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_OFF;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    on    = 1'b0;
    ready = 1'b0;
    unique case (state)
      ST_OFF:  ready = 1'b1;
      ST_ON:   on    = 1'b1;
      ST_COOL: ready = off_done;
      default: ;
    endcase
  end

endmodule

// File: rtl/actuator_arbiter.sv
// actuator_arbiter: power-budgeted, interlocked grant arbiter for four
// washer actuators. ACTUATOR_ARBITER_STATS_EN enables the deny counter.
module actuator_arbiter
  import washer_pkg::*;
#(
  parameter logic [4:0] POWER_BUDGET     = DEF_BUDGET,
  parameter logic [3:0] W_VALVE          = DEF_W_VALVE,
  parameter logic [3:0] W_HEATER         = DEF_W_HEATER,
  parameter logic [3:0] W_DRAIN          = DEF_W_DRAIN,
  parameter logic [3:0] W_MOTOR          = DEF_W_MOTOR,
  parameter logic [7:0] MIN_ON           = DEF_MIN_ON,
  parameter logic [7:0] MIN_OFF          = DEF_MIN_OFF,
  parameter logic [9:0] HEATER_MIN_LEVEL = DEF_HEATER_LEVEL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       door_locked,
  input  logic       vibration_sensor,
  input  logic [9:0] water_level_sensor,
  input  logic       fault_clr,
  output logic [3:0] grant,
  output logic       fault,
  output logic [4:0] power_used,
  output logic [7:0] deny_count
);

  logic [3:0] on;
  logic [3:0] ready;
  logic [3:0] hold_ok;
  logic [3:0] cand;
  logic [3:0] start;
  logic [3:0] budget_deny;
  logic       level_ok;

  assign level_ok = (water_level_sensor >= HEATER_MIN_LEVEL);

  assign hold_ok[IDX_VALVE]  = door_locked && !on[IDX_DRAIN];
  assign hold_ok[IDX_DRAIN]  = door_locked && !on[IDX_VALVE];
  assign hold_ok[IDX_MOTOR]  = door_locked && !vibration_sensor;
  assign hold_ok[IDX_HEATER] = door_locked && level_ok;

  assign cand = req & ready & hold_ok & {4{!fault}};

  // Fixed-priority walk: each grant consumes budget before the next
  // actuator is checked; the budget base is what is already on.
  always_comb begin
    logic [6:0] acc;
    logic       go_drain;
    start       = '0;
    budget_deny = '0;
    go_drain    = 1'b0;
    acc         = {2'b00, power_used};

    if (cand[IDX_DRAIN]) begin
      if (fits(acc, W_DRAIN, POWER_BUDGET)) begin
        go_drain         = 1'b1;
        start[IDX_DRAIN] = 1'b1;
        acc              = add_w(acc, W_DRAIN);
      end else begin
        budget_deny[IDX_DRAIN] = 1'b1;
      end
    end

    if (cand[IDX_VALVE] && !go_drain) begin
      if (fits(acc, W_VALVE, POWER_BUDGET)) begin
        start[IDX_VALVE] = 1'b1;
        acc              = add_w(acc, W_VALVE);
      end else begin
        budget_deny[IDX_VALVE] = 1'b1;
      end
    end

    if (cand[IDX_MOTOR]) begin
      if (fits(acc, W_MOTOR, POWER_BUDGET)) begin
        start[IDX_MOTOR] = 1'b1;
        acc              = add_w(acc, W_MOTOR);
      end else begin
        budget_deny[IDX_MOTOR] = 1'b1;
      end
    end

    if (cand[IDX_HEATER]) begin
      if (fits(acc, W_HEATER, POWER_BUDGET)) begin
        start[IDX_HEATER] = 1'b1;
      end else begin
        budget_deny[IDX_HEATER] = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N_ACT; i++) begin : g_act
    actuator_dwell #(
      .MIN_ON  (MIN_ON),
      .MIN_OFF (MIN_OFF)
    ) u_dwell (
      .clk     (clk),
      .reset   (reset),
      .req     (req[i]),
      .start   (start[i]),
      .hold_ok (hold_ok[i]),
      .on      (on[i]),
      .ready   (ready[i])
    );
  end

  assign grant = on;

  assign power_used = ({1'b0, W_VALVE}  & {5{grant[IDX_VALVE]}})
                    + ({1'b0, W_HEATER} & {5{grant[IDX_HEATER]}})
                    + ({1'b0, W_DRAIN}  & {5{grant[IDX_DRAIN]}})
                    + ({1'b0, W_MOTOR}  & {5{grant[IDX_MOTOR]}});

  // Setting wins over clearing, so a clear issued as the door opens
  // leaves the fault latched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault <= 1'b0;
    end else if (!door_locked && (|grant)) begin
      fault <= 1'b1;
    end else if (fault_clr && door_locked) begin
      fault <= 1'b0;
    end
  end

`ifdef ACTUATOR_ARBITER_STATS_EN
  logic [7:0] deny_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deny_q <= '0;
    end else if ((|budget_deny) && (deny_q != 8'hFF)) begin
      deny_q <= deny_q + 8'd1;
    end
  end

  assign deny_count = deny_q;
`else
  logic unused_deny;

  assign unused_deny = ^budget_deny;
  assign deny_count  = '0;
`endif

endmodule

// File: tb/tb_actuator_arbiter.sv
// tb_actuator_arbiter: directed scenario tasks for actuator_arbiter
// with hand-computed expectations for the default parameter set.
module tb_actuator_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       door_locked;
  logic       vibration_sensor;
  logic [9:0] water_level_sensor;
  logic       fault_clr;
  logic [3:0] grant;
  logic       fault;
  logic [4:0] power_used;
  logic [7:0] deny_count;

  int passed = 0;
  int total  = 0;

`ifdef ACTUATOR_ARBITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  actuator_arbiter dut (
    .clk                (clk),
    .reset              (reset),
    .req                (req),
    .door_locked        (door_locked),
    .vibration_sensor   (vibration_sensor),
    .water_level_sensor (water_level_sensor),
    .fault_clr          (fault_clr),
    .grant              (grant),
    .fault              (fault),
    .power_used         (power_used),
    .deny_count         (deny_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset              = 1'b0;
    req                = '0;
    door_locked        = 1'b1;
    vibration_sensor   = 1'b0;
    water_level_sensor = 10'd130;
    fault_clr          = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  function automatic logic [7:0] exp_deny(input int n);
    return STATS ? 8'(n) : 8'd0;
  endfunction

  task automatic test_reset();
    #3;
    total++;
    if (grant !== 4'b0000) $display("FAIL rst_grant: got %b want 0000", grant);
    else passed++;
    total++;
    if (fault !== 1'b0) $display("FAIL rst_fault: got %b want 0", fault);
    else passed++;
    total++;
    if (power_used !== 5'd0) $display("FAIL rst_power: got %0d want 0", power_used);
    else passed++;
    total++;
    if (deny_count !== 8'd0) $display("FAIL rst_deny: got %0d want 0", deny_count);
    else passed++;
    reset = 1'b1;
  endtask

  task automatic test_budget();
    do_reset();
    req = 4'b0011;
    #1;
    total++;
    if (grant !== 4'b0000) $display("FAIL bud_latency: got %b want 0000", grant);
    else passed++;
    step();
    total++;
    if (grant !== 4'b0011) $display("FAIL bud_grant: got %b want 0011", grant);
    else passed++;
    total++;
    if (power_used !== 5'd9) $display("FAIL bud_power: got %0d want 9", power_used);
    else passed++;
    req = 4'b1011;
    for (int n = 1; n <= 3; n++) begin
      step();
      total++;
      if (grant !== 4'b0011)
        $display("FAIL bud_motor_denied%0d: got %b want 0011", n, grant);
      else passed++;
      total++;
      if (deny_count !== exp_deny(n))
        $display("FAIL bud_deny%0d: got %0d want %0d", n, deny_count, exp_deny(n));
      else passed++;
      if (n == 2) req = 4'b1001;
    end
    step();
    total++;
    if (grant !== 4'b0001) $display("FAIL bud_heater_off: got %b want 0001", grant);
    else passed++;
    total++;
    if (deny_count !== exp_deny(4))
      $display("FAIL bud_deny4: got %0d want %0d", deny_count, exp_deny(4));
    else passed++;
    step();
    total++;
    if (grant !== 4'b1001) $display("FAIL bud_motor_late: got %b want 1001", grant);
    else passed++;
    total++;
    if (power_used !== 5'd6) $display("FAIL bud_power2: got %0d want 6", power_used);
    else passed++;
    total++;
    if (deny_count !== exp_deny(4))
      $display("FAIL bud_deny_hold: got %0d want %0d", deny_count, exp_deny(4));
    else passed++;
  endtask

  task automatic test_budget_edge();
    do_reset();
    req = 4'b0110;
    step();
    total++;
    if (grant !== 4'b0110) $display("FAIL edge_grant: got %b want 0110", grant);
    else passed++;
    total++;
    if (power_used !== 5'd10) $display("FAIL edge_power: got %0d want 10", power_used);
    else passed++;
    req = 4'b1110;
    step();
    total++;
    if (grant !== 4'b0110) $display("FAIL edge_full: got %b want 0110", grant);
    else passed++;
    total++;
    if (deny_count !== exp_deny(1))
      $display("FAIL edge_deny: got %0d want %0d", deny_count, exp_deny(1));
    else passed++;
  endtask

  task automatic test_heater_level();
    do_reset();
    req                = 4'b0010;
    water_level_sensor = 10'd119;
    step();
    total++;
    if (grant !== 4'b0000) $display("FAIL lvl_low: got %b want 0000", grant);
    else passed++;
    total++;
    if (deny_count !== 8'd0) $display("FAIL lvl_nodeny: got %0d want 0", deny_count);
    else passed++;
    water_level_sensor = 10'd120;
    step();
    total++;
    if (grant !== 4'b0010) $display("FAIL lvl_exact: got %b want 0010", grant);
    else passed++;
    water_level_sensor = 10'd119;
    step();
    total++;
    if (grant !== 4'b0000) $display("FAIL lvl_loss: got %b want 0000", grant);
    else passed++;
  endtask

  task automatic test_min_dwell();
    logic [8:0] pat;
    pat = 9'b1_0000_1111;
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 9; i++) begin
      step();
      total++;
      if (grant[0] !== pat[i])
        $display("FAIL dwell_e%0d: got %b want %b", i + 1, grant[0], pat[i]);
      else passed++;
      if (i == 0) req = 4'b0000;
      if (i == 5) req = 4'b0001;
    end
  endtask

  task automatic test_rereq();
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b0000;
    step();
    step();
    req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (grant !== 4'b0001) $display("FAIL rereq_%0d: got %b want 0001", i, grant);
      else passed++;
    end
  endtask

  task automatic test_drain_pending();
    logic [3:0] pat [4];
    pat = '{4'b0001, 4'b0001, 4'b0000, 4'b0100};
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b0101;
    step();
    total++;
    if (grant !== 4'b0001) $display("FAIL drain_block: got %b want 0001", grant);
    else passed++;
    req = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (grant !== pat[i])
        $display("FAIL drain_e%0d: got %b want %b", i + 3, grant, pat[i]);
      else passed++;
    end
    total++;
    if (power_used !== 5'd2) $display("FAIL drain_power: got %0d want 2", power_used);
    else passed++;
  endtask

  task automatic test_vibration();
    logic [3:0] pat;
    pat = 4'b1000;
    do_reset();
    req = 4'b1000;
    step();
    total++;
    if (grant !== 4'b1000) $display("FAIL vib_on: got %b want 1000", grant);
    else passed++;
    vibration_sensor = 1'b1;
    step();
    total++;
    if (grant !== 4'b0000) $display("FAIL vib_cut: got %b want 0000", grant);
    else passed++;
    vibration_sensor = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (grant[3] !== pat[i])
        $display("FAIL vib_cool%0d: got %b want %b", i, grant[3], pat[i]);
      else passed++;
    end
  endtask

  task automatic test_fault();
    do_reset();
    req = 4'b0011;
    step();
    door_locked = 1'b0;
    step();
    total++;
    if (grant !== 4'b0000) $display("FAIL flt_cut: got %b want 0000", grant);
    else passed++;
    total++;
    if (fault !== 1'b1) $display("FAIL flt_set: got %b want 1", fault);
    else passed++;
    door_locked = 1'b1;
    repeat (5) step();
    total++;
    if (grant !== 4'b0000) $display("FAIL flt_block: got %b want 0000", grant);
    else passed++;
    door_locked = 1'b0;
    fault_clr   = 1'b1;
    step();
    total++;
    if (fault !== 1'b1) $display("FAIL flt_clr_open: got %b want 1", fault);
    else passed++;
    door_locked = 1'b1;
    step();
    total++;
    if (fault !== 1'b0) $display("FAIL flt_clr: got %b want 0", fault);
    else passed++;
    fault_clr = 1'b0;
    step();
    total++;
    if (grant !== 4'b0011) $display("FAIL flt_regrant: got %b want 0011", grant);
    else passed++;
    door_locked = 1'b0;
    fault_clr   = 1'b1;
    step();
    total++;
    if (fault !== 1'b1) $display("FAIL flt_simul: got %b want 1", fault);
    else passed++;
    fault_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0001;
    step();
    reset = 1'b0;
    #1;
    total++;
    if (grant !== 4'b0000) $display("FAIL mid_async: got %b want 0000", grant);
    else passed++;
    total++;
    if (power_used !== 5'd0) $display("FAIL mid_power: got %0d want 0", power_used);
    else passed++;
    #1;
    reset = 1'b1;
    step();
    total++;
    if (grant !== 4'b0001) $display("FAIL mid_regrant: got %b want 0001", grant);
    else passed++;
  endtask

  initial begin
    reset              = 1'b0;
    req                = '0;
    door_locked        = 1'b1;
    vibration_sensor   = 1'b0;
    water_level_sensor = 10'd130;
    fault_clr          = 1'b0;
    test_reset();
    test_budget();
    test_budget_edge();
    test_heater_level();
    test_min_dwell();
    test_rereq();
    test_drain_pending();
    test_vibration();
    test_fault();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
